// File: rtl/disp_router_n_pkg.sv
// Shared definitions for the N-way dispatcher: input word field positions,
// drop counter width and the saturating increment used by the drop counter.
package disp_router_n_pkg;

  localparam int DROP_CNT_W = 16;

  // Input word layout is {class, dest, payload}, class at the MSBs.
  function automatic int payload_lsb();
    return 0;
  endfunction

  function automatic int dest_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int class_lsb(input int data_w, input int dest_w);
    return data_w + dest_w;
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/disp_fifo.sv
// Per-output FIFO: array storage, registered occupancy drives full/empty/almost_full.
// Head is presented as soon as the write edge has passed (no fall-through).
module disp_fifo #(
  parameter int W        = 9,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         valid,
  output logic         full,
  output logic         almost_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  // Occupancy (not a pointer MSB) separates full from empty when the pointers meet.
  logic [CW-1:0] count_reg;
  logic          push_fire;
  logic          pop_fire;

  assign valid       = (count_reg != '0);
  assign full        = (count_reg == CW'(DEPTH));
  assign almost_full = (count_reg >= CW'(AF_LEVEL));
  assign push_fire   = push & ~full;
  assign pop_fire    = pop & valid;
  assign head_data   = valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire && !reset) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/disp_router_n.sv
// N-way class-aware dispatcher: decodes {class,dest,payload}, rejects illegal
// words with error pulses, and queues legal words into per-output FIFOs.
module disp_router_n
  import disp_router_n_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEST_W    = 1,
  parameter int CLASS_W   = 1,
  parameter int NUM_OUT   = 2,
  parameter int NUM_CLASS = 2,
  parameter int DEPTH     = 4,
  parameter int AF_LEVEL  = 3,
  parameter int DROP_MODE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CLASS_W+DEST_W+DATA_W-1:0] in_data,
  output logic [NUM_OUT-1:0]           out_valid,
  input  logic [NUM_OUT-1:0]           out_ready,
  output logic [NUM_OUT*DATA_W-1:0]    out_data,
  output logic [NUM_OUT*CLASS_W-1:0]   out_class,
  output logic [NUM_OUT-1:0]           almost_full,
  output logic                         error_class,
  output logic                         error_route,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int ENTRY_W = CLASS_W + DATA_W;

  logic [CLASS_W-1:0]    cls;
  logic [DEST_W-1:0]     dst;
  logic [DATA_W-1:0]     pay;
  logic                  class_bad;
  logic                  route_bad;
  logic                  legal;
  logic                  accept;
  logic                  target_full;
  logic                  drop;
  logic [NUM_OUT-1:0]    sel;
  logic [NUM_OUT-1:0]    push;
  logic [NUM_OUT-1:0]    fifo_full;
  logic                  error_class_reg;
  logic                  error_route_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  assign cls = in_data[class_lsb(DATA_W, DEST_W) +: CLASS_W];
  assign dst = in_data[dest_lsb(DATA_W) +: DEST_W];
  assign pay = in_data[payload_lsb() +: DATA_W];

  assign class_bad = (int'(cls) >= NUM_CLASS);
  assign route_bad = (int'(dst) >= NUM_OUT);
  assign legal     = ~class_bad & ~route_bad;

  // sel is all-zero for an out-of-range dest, so target_full is 0 there too.
  assign target_full = |(sel & fifo_full);
  assign in_ready    = ~legal | (DROP_MODE != 0) | ~target_full;
  assign accept      = in_valid & in_ready;
  assign drop        = accept & legal & target_full;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_chan
      logic [ENTRY_W-1:0] head;

      assign sel[gi]  = (int'(dst) == gi);
      assign push[gi] = accept & legal & sel[gi] & ~fifo_full[gi];

      disp_fifo #(
        .W        (ENTRY_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
      ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push[gi]),
        .push_data   ({cls, pay}),
        .pop         (out_ready[gi]),
        .head_data   (head),
        .valid       (out_valid[gi]),
        .full        (fifo_full[gi]),
        .almost_full (almost_full[gi])
      );

      assign out_data[gi*DATA_W +: DATA_W]    = head[DATA_W-1:0];
      assign out_class[gi*CLASS_W +: CLASS_W] = head[ENTRY_W-1 -: CLASS_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      error_class_reg <= 1'b0;
      error_route_reg <= 1'b0;
      drop_cnt_reg    <= '0;
    end else begin
      error_class_reg <= accept & class_bad;
      error_route_reg <= accept & route_bad;
      if (drop) drop_cnt_reg <= sat_inc(drop_cnt_reg);
    end
  end

  assign error_class = error_class_reg;
  assign error_route = error_route_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule
